// File: rtl/sobel_pkg.sv
// Shared widths, gradient types and the magnitude saturation helper for the Sobel stage.
package sobel_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GRAD_W  = DATA_W + 3;
  localparam int unsigned MAG_MAX = (1 << DATA_W) - 1;

  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic        [GRAD_W-1:0] mag_t;

  // Clamp an |Gx|+|Gy| sum to the pixel range.
  function automatic logic [DATA_W-1:0] sat_mag(input mag_t mag);
    if (mag > mag_t'(MAG_MAX)) begin
      return DATA_W'(MAG_MAX);
    end
    return mag[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_gradient_core_if.sv
// Column-in / magnitude-out stream between the line-buffer chain and the Sobel core.
interface sobel_gradient_core_if #(
  parameter int unsigned DATA_W = sobel_pkg::DATA_W
);

  logic              we_i;
  logic              sof_i;
  logic [DATA_W-1:0] top_i;
  logic [DATA_W-1:0] mid_i;
  logic [DATA_W-1:0] bot_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              done_o;

  modport master (
    output we_i, sof_i, top_i, mid_i, bot_i,
    input  data_o, valid_o, done_o
  );

  modport slave (
    input  we_i, sof_i, top_i, mid_i, bot_i,
    output data_o, valid_o, done_o
  );

endinterface

// File: rtl/sobel_window_3x3.sv
// Sliding 3x3 pixel window with row column counter; flags which accepted columns
// complete a full window and which one is the last of the row.
module sobel_window_3x3 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic                        sof_i,
  input  logic [DATA_W-1:0]           top_i,
  input  logic [DATA_W-1:0]           mid_i,
  input  logic [DATA_W-1:0]           bot_i,
  output logic [2:0][2:0][DATA_W-1:0] win_o,
  output logic                        win_valid_o,
  output logic                        win_last_o
);

  localparam int unsigned     CntW    = $clog2(IMG_W);
  localparam logic [CntW-1:0] LastCol = CntW'(IMG_W - 1);

  logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [CntW-1:0]             col_idx;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;

  always_comb begin
    // sof_i only matters on an accepted column; it forces that column to index 0.
    col_idx = sof_i ? '0 : cnt_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (we_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_i;
      win_d[1][2] = mid_i;
      win_d[2][2] = bot_i;
      cnt_d       = (col_idx == LastCol) ? '0 : col_idx + CntW'(1);
      valid_d     = (col_idx >= CntW'(2));
      last_d      = (col_idx == LastCol);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign win_o       = win_q;
  assign win_valid_o = valid_q;
  assign win_last_o  = last_q;

endmodule

// File: rtl/sobel_gradient_core.sv
// Streaming 3x3 Sobel stage: window -> registered Gx/Gy -> registered saturated |Gx|+|Gy|.
// Non-stalling; valid and row-end flags ride alongside the data.
module sobel_gradient_core #(
  parameter int unsigned DATA_W = sobel_pkg::DATA_W,
  parameter int unsigned IMG_W  = 640
) (
  input logic                 clk,
  input logic                 rst,
  sobel_gradient_core_if.slave core_io
);

  import sobel_pkg::*;

  logic [2:0][2:0][DATA_W-1:0] win;
  logic                        win_valid;
  logic                        win_last;

  grad_t             gx_q, gx_d;
  grad_t             gy_q, gy_d;
  logic              v1_q, l1_q;
  mag_t              mag;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, done_q;

  sobel_window_3x3 #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .we_i        (core_io.we_i),
    .sof_i       (core_io.sof_i),
    .top_i       (core_io.top_i),
    .mid_i       (core_io.mid_i),
    .bot_i       (core_io.bot_i),
    .win_o       (win),
    .win_valid_o (win_valid),
    .win_last_o  (win_last)
  );

  // 1-2-1 weighted sum of three pixels, zero-extended into the signed gradient width.
  function automatic grad_t wsum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic [DATA_W-1:0] c);
    return grad_t'(a) + (grad_t'(b) <<< 1) + grad_t'(c);
  endfunction

  function automatic mag_t abs_g(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

  always_comb begin
    gx_d = wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]);
    gy_d = wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]);
  end

  // |Gx|+|Gy| peaks at 2040, which still fits the unsigned gradient width.
  always_comb begin
    mag    = abs_g(gx_q) + abs_g(gy_q);
    data_d = v1_q ? sat_mag(mag) : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_q    <= '0;
      gy_q    <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (win_valid) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      v1_q    <= win_valid;
      l1_q    <= win_last;
      data_q  <= data_d;
      valid_q <= v1_q;
      done_q  <= v1_q & l1_q;
    end
  end

  assign core_io.data_o  = data_q;
  assign core_io.valid_o = valid_q;
  assign core_io.done_o  = done_q;

endmodule

// File: tb/tb_sobel_gradient_core.sv
// Directed, table-driven bench for sobel_gradient_core with IMG_W = 8.
module tb_sobel_gradient_core;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sobel_gradient_core_if #(.DATA_W(DW)) bus ();

  sobel_gradient_core #(
    .DATA_W (DW),
    .IMG_W  (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .core_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    int             kind;
    int             gap;
    logic [0:5][7:0] e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_d[$];
  bit         got_done[$];
  int         got_cyc[$];
  int         stray_done = 0;

  always @(negedge clk) begin
    if (bus.valid_o) begin
      got_d.push_back(bus.data_o);
      got_done.push_back(bus.done_o);
      got_cyc.push_back(cyc);
    end else if (bus.done_o) begin
      stray_done++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_done.delete();
    got_cyc.delete();
  endtask

  task automatic put(input bit we, input bit sof, input logic [7:0] t, input logic [7:0] m,
                     input logic [7:0] b);
    bus.we_i  = we;
    bus.sof_i = sof;
    bus.top_i = t;
    bus.mid_i = m;
    bus.bot_i = b;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles carry junk pixels and stray sof_i, all of which must be ignored.
  task automatic idle(input int n);
    repeat (n) put(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd0 : 8'd50;
      2:       return (c < 4) ? 8'd0 : 8'd255;
      3:       return (r == 0) ? 8'd0 : (r == 1) ? 8'd128 : 8'd255;
      4:       return 8'(c * 10);
      5:       return 8'(200 - c * 20);
      6:       return (r == 2) ? 8'(c * 5 + 30) : 8'(c * 5);
      7:       return (r == 0) ? 8'd70 : (r == 1) ? 8'd40 : 8'd20;
      default: return 8'd0;
    endcase
  endfunction

  task automatic send_col(input int kind, input int c, input bit sof);
    put(1'b1, sof, pix(kind, 0, c), pix(kind, 1, c), pix(kind, 2, c));
  endtask

  task automatic run_row(input int kind, input int gap, input bit sof0, output int c2_edge);
    c2_edge = 0;
    for (int c = 0; c < 8; c++) begin
      send_col(kind, c, sof0 && (c == 0));
      if (c == 2) c2_edge = cyc;
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic cmp_out(input string name, input int idx, input logic [7:0] exp_d,
                         input bit exp_done);
    logic [7:0] d;
    bit         dn;
    d  = (idx < got_d.size()) ? got_d[idx] : 8'hxx;
    dn = (idx < got_done.size()) ? got_done[idx] : 1'b0;
    check($sformatf("%s data[%0d]", name, idx), 32'(d), 32'(exp_d));
    check($sformatf("%s done[%0d]", name, idx), 32'(dn), 32'(exp_done));
  endtask

  vec_t vt[9];

  initial begin
    int c2;

    vt[0] = '{name: "flat",    kind: 0, gap: 0, e: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vt[1] = '{name: "vedge",   kind: 1, gap: 0, e: {8'd0, 8'd0, 8'd200, 8'd200, 8'd0, 8'd0}};
    vt[2] = '{name: "sat_gx",  kind: 2, gap: 0, e: {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0}};
    vt[3] = '{name: "sat_gy",  kind: 3, gap: 0,
              e: {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}};
    vt[4] = '{name: "bubbles", kind: 1, gap: 1, e: {8'd0, 8'd0, 8'd200, 8'd200, 8'd0, 8'd0}};
    vt[5] = '{name: "ramp",    kind: 4, gap: 0, e: {8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80}};
    vt[6] = '{name: "negramp", kind: 5, gap: 0,
              e: {8'd160, 8'd160, 8'd160, 8'd160, 8'd160, 8'd160}};
    vt[7] = '{name: "diag",    kind: 6, gap: 0,
              e: {8'd160, 8'd160, 8'd160, 8'd160, 8'd160, 8'd160}};
    vt[8] = '{name: "neg_gy",  kind: 7, gap: 0,
              e: {8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}};

    bus.we_i  = 1'b0;
    bus.sof_i = 1'b0;
    bus.top_i = '0;
    bus.mid_i = '0;
    bus.bot_i = '0;

    // Reset held with random traffic.
    for (int i = 0; i < 10; i++) begin
      put(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
          8'($urandom));
      @(negedge clk);
      check($sformatf("rst_hold outs[%0d]", i),
            {22'd0, bus.data_o, bus.valid_o, bus.done_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Table-driven rows, each starting with sof_i.
    for (int v = 0; v < 9; v++) begin
      clear_mon();
      stray_done = 0;
      run_row(vt[v].kind, vt[v].gap, 1'b1, c2);
      idle(5);
      check({vt[v].name, " count"}, 32'(got_d.size()), 32'd6);
      for (int i = 0; i < 6; i++) cmp_out(vt[v].name, i, vt[v].e[i], i == 5);
      check({vt[v].name, " stray_done"}, 32'(stray_done), 32'd0);
      check({vt[v].name, " hold"}, 32'(bus.data_o), 32'(vt[v].e[5]));
      if (vt[v].kind == 0 && got_cyc.size() > 0) begin
        check("flat latency", 32'(got_cyc[0]), 32'(c2 + 2));
      end
      if (vt[v].gap > 0) begin
        for (int i = 1; i < got_cyc.size(); i++) begin
          check($sformatf("bubble spacing[%0d]", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd2);
        end
      end
    end

    // Asynchronous reset mid-row must clear outputs without a clock edge.
    clear_mon();
    for (int c = 0; c < 6; c++) send_col(3, c, c == 0);
    check("pre_rst valid", 32'(bus.valid_o), 32'd1);
    check("pre_rst data", 32'(bus.data_o), 32'd255);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst data", 32'(bus.data_o), 32'd0);
    check("async_rst valid", 32'(bus.valid_o), 32'd0);
    check("async_rst done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);

    // First accepted column after reset is column 0 even without sof_i.
    clear_mon();
    stray_done = 0;
    run_row(1, 0, 1'b0, c2);
    idle(5);
    check("post_rst count", 32'(got_d.size()), 32'd6);
    for (int i = 0; i < 6; i++) cmp_out("post_rst", i, vt[1].e[i], i == 5);

    // Resync: partial ramp row, then sof_i restarts with a fresh vertical-edge row.
    clear_mon();
    for (int c = 0; c < 4; c++) send_col(4, c, c == 0);
    run_row(1, 0, 1'b1, c2);
    idle(5);
    check("resync count", 32'(got_d.size()), 32'd8);
    cmp_out("resync", 0, 8'd80, 1'b0);
    cmp_out("resync", 1, 8'd80, 1'b0);
    for (int i = 0; i < 6; i++) cmp_out("resync", i + 2, vt[1].e[i], i == 5);

    // Back-to-back rows relying on counter wrap.
    clear_mon();
    run_row(1, 0, 1'b1, c2);
    run_row(1, 0, 1'b0, c2);
    run_row(1, 0, 1'b0, c2);
    idle(5);
    check("b2b count", 32'(got_d.size()), 32'd18);
    for (int i = 0; i < 18; i++) cmp_out("b2b", i, vt[1].e[i % 6], (i % 6) == 5);
    check("b2b stray_done", 32'(stray_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_gradient_core.md
# sobel_gradient_core

Streaming 3x3 Sobel gradient stage that sits directly downstream of the `fifo_single_line_buffer` chain. Each accepted cycle it takes one column of three vertically adjacent pixels (rows y-1, y, y+1) from the line buffers and forms a sliding 3x3 window. It computes Gx and Gy and emits a saturated 8-bit magnitude |Gx|+|Gy| through a fixed-latency, non-stalling pipeline. It also pulses `done_o` on the last output of each image row.

## Interface
- `DATA_W`, 8 — pixel width.
- `IMG_W`, 640 — pixels per image row; minimum 3.
- `clk` input 1 — single clock; all state changes on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `we_i` input 1 — the column on `top_i`/`mid_i`/`bot_i` is valid this cycle.
- `sof_i` input 1 — start of row; when sampled with `we_i`=1, the accepted column is column 0.
- `top_i` input DATA_W — pixel (x, y-1).
- `mid_i` input DATA_W — pixel (x, y).
- `bot_i` input DATA_W — pixel (x, y+1).
- `data_o` output DATA_W — gradient magnitude, saturated.
- `valid_o` output 1 — `data_o` is valid this cycle.
- `done_o` output 1 — one-cycle pulse coincident with the `valid_o` of column IMG_W-1.

## Operation
- **Window:** 3 columns × 3 rows of registers. On `we_i`=1, shift old→older and load the new column as the newest. Notation: p[r][c], where r=0 is top and c=2 is newest. With `we_i`=0, the window holds.
- **Column counter:** range 0..IMG_W-1.
  - On `we_i`=1: increment, wrapping to 0 after IMG_W-1.
  - On `we_i`=1 with `sof_i`=1: the accepted column is treated as column 0 and the counter restarts from it.
  - `sof_i` without `we_i` is ignored.
- **Window valid:** the accepted column index is ≥2. Exactly IMG_W-2 outputs are produced per row; the first two columns of every row produce none.
- **Gradients:** signed, 11 bits for DATA_W=8 (generally DATA_W+3).
  - Gx = (p0[2]+2p1[2]+p2[2]) − (p0[0]+2p1[0]+p2[0]).
  - Gy = (p2[0]+2p2[1]+p2[2]) − (p0[0]+2p0[1]+p0[2]).
  - Range ±1020.
- **Magnitude:** |Gx|+|Gy|, unsigned 11 bits (max 2040). Values >255 saturate to 255; otherwise pass through unchanged.
- **Pipeline:** no backpressure. A valid bit and a last-column bit travel with the data. Gaps in `we_i` become bubbles; output values are unaffected by gaps.

## Timing
- **Reset** (`rst`=0, asynchronous): all window registers, counter, pipeline data and flags clear immediately. `data_o`=0, `valid_o`=0, `done_o`=0. In-flight results are discarded. After release, the first accepted column is column 0.
- **Latency:** a column sampled with `we_i`=1 at edge N enters the window at N. Gx/Gy are registered at N+1, and `data_o`/`valid_o` are registered at N+2. The output is visible in the cycle after edge N+2 (3 edges of latency).
- **`valid_o` rate:** `valid_o` is high for exactly one cycle per qualifying accepted column. It can be high on consecutive cycles.
- **`done_o` timing:** `done_o` is high only together with `valid_o` for column IMG_W-1. It is never high otherwise.
- **Outputs when idle:** `data_o` holds its last value when `valid_o`=0.
- **Mid-row `sof_i`:** restarts the column count. Old window contents do not produce an output for the new row's columns 0 and 1. Results already in flight still emit, with their original `done_o` flag.
- **Row wrap:** on wrap without `sof_i`, the next accepted column is column 0. No output is produced across the row boundary.

## Structure
- **Package `sobel_pkg`:**
  - DATA_W default.
  - GRAD_W = DATA_W+3.
  - MAG_MAX = 2^DATA_W − 1.
  - Typedef for the signed gradient.
  - Saturation function.
- **Sub-module `sobel_window_3x3`:**
  - Contents: the 9 window registers, the column counter, `sof_i` handling, and the window-valid/last-column flags.
  - Ownership: the top level owns the gradient and magnitude pipeline.
- **Target size:** about 200 lines of RTL.

## Test plan
All scenarios use IMG_W=8.
- **Reset:** hold `rst`=0 with random inputs toggling → `data_o`=0, `valid_o`=0, `done_o`=0 throughout. Assert reset mid-row → outputs clear in the same cycle, without waiting for an edge.
- **Flat image:** one row of all pixels = 100, `we_i` continuous, `sof_i` on the first column → 6 outputs, all 0. First `valid_o` 3 edges after column 2 is sampled. `done_o` only on the 6th output.
- **Vertical edge:** all rows = 0 for columns 0–3 and 50 for columns 4–7 → outputs for columns 2..7 are 0, 0, 200, 200, 0, 0.
- **Saturation:**
  - Columns 0–3 = 0, columns 4–7 = 255 → outputs for columns 4 and 5 = 255 (Gx=1020).
  - Separately, `top_i`=0, `mid_i`=128, `bot_i`=255 everywhere → all 6 outputs = 255 (Gy=1020).
- **Bubbles:** repeat the vertical-edge row with `we_i` high every other cycle → identical 6 values in order, `valid_o` spaced 2 cycles apart, a single `done_o`.
- **Resync:** assert `sof_i` at column 4 of a row, then feed a new row → no outputs for the new columns 0–1. The new row produces 6 outputs and `done_o` aligned to its column 7. Back-to-back rows without `sof_i` also produce 6 outputs per row.
